// File: rtl/lut_prober.sv
// lut_prober: sweeps all four input patterns of a 2-input logic unit,
// recovers its truth table and flags any sample that disagrees with the
// first sweep.
module lut_prober #(
  parameter int SETTLE = 1,
  parameter int PASSES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       probe_a,
  output logic       probe_b,
  input  logic       dut_out,
  output logic [3:0] func_learned,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST  = 4'(SETTLE - 1);
  localparam logic [1:0] PASS_LAST = 2'(PASSES - 1);

  state_t     state_reg, state_next;
  logic [1:0] idx_reg, idx_next;
  logic [1:0] pass_reg, pass_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [3:0] shadow_reg, shadow_next;
  logic [3:0] func_reg, func_next;
  logic       err_reg, err_next;
  logic       probe_a_reg, probe_a_next;
  logic       probe_b_reg, probe_b_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;

  // Sample strobe: the settle counter is about to reach SETTLE on this edge.
  logic       sample;
  logic [3:0] shadow_upd;
  logic [3:0] mismatch;

  assign sample = (state_reg == ST_SETTLE) && (cnt_reg == CNT_LAST);

  // Per truth-table bit: capture on pass 0, compare on every later pass.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    logic hit;
    assign hit            = sample && (idx_reg == 2'(gi));
    assign shadow_upd[gi] = (hit && (pass_reg == 2'd0)) ? dut_out : shadow_reg[gi];
    assign mismatch[gi]   = hit && (pass_reg != 2'd0) && (dut_out != shadow_reg[gi]);
  end

  // Next-state and registered-output logic for the probe sequencer.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    pass_next    = pass_reg;
    cnt_next     = cnt_reg;
    shadow_next  = shadow_reg;
    func_next    = func_reg;
    err_next     = err_reg;
    probe_a_next = probe_a_reg;
    probe_b_next = probe_b_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        probe_a_next = 1'b0;
        probe_b_next = 1'b0;
        busy_next    = 1'b0;
        if (start) begin
          state_next = ST_SETTLE;
          idx_next   = 2'd0;
          pass_next  = 2'd0;
          cnt_next   = 4'd0;
          err_next   = 1'b0;
          busy_next  = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (sample) begin
          cnt_next    = 4'd0;
          shadow_next = shadow_upd;
          err_next    = err_reg | (|mismatch);
          if ((idx_reg == 2'd3) && (pass_reg == PASS_LAST)) begin
            // Final sample: publish pass-0 table and drop the probe pins.
            state_next   = ST_DONE;
            func_next    = shadow_upd;
            idx_next     = 2'd0;
            pass_next    = 2'd0;
            probe_a_next = 1'b0;
            probe_b_next = 1'b0;
            busy_next    = 1'b0;
            done_next    = 1'b1;
          end else begin
            idx_next     = idx_reg + 2'd1;
            probe_a_next = idx_next[1];
            probe_b_next = idx_next[0];
            if (idx_reg == 2'd3) begin
              pass_next = pass_reg + 2'd1;
            end
          end
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end

      ST_DONE: begin
        state_next   = ST_IDLE;
        probe_a_next = 1'b0;
        probe_b_next = 1'b0;
        busy_next    = 1'b0;
      end

      default: begin
        state_next   = ST_IDLE;
        probe_a_next = 1'b0;
        probe_b_next = 1'b0;
        busy_next    = 1'b0;
      end
    endcase
  end

  // State and output registers; active-low synchronous reset wins over start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= 2'd0;
      pass_reg    <= 2'd0;
      cnt_reg     <= 4'd0;
      shadow_reg  <= 4'd0;
      func_reg    <= 4'b0000;
      err_reg     <= 1'b0;
      probe_a_reg <= 1'b0;
      probe_b_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pass_reg    <= pass_next;
      cnt_reg     <= cnt_next;
      shadow_reg  <= shadow_next;
      func_reg    <= func_next;
      err_reg     <= err_next;
      probe_a_reg <= probe_a_next;
      probe_b_reg <= probe_b_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign probe_a      = probe_a_reg;
  assign probe_b      = probe_b_reg;
  assign func_learned = func_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_lut_prober.sv
// tb_lut_prober: three prober instances (SETTLE/PASSES = 1/2, 3/1, 15/4),
// each driving a modelled 2-input unit; checked every cycle against a
// timing-based behavioural model plus directed literal expectations.
module tb_lut_prober;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n, start, probe_a, probe_b, dut_out, busy, done, err;
  logic [2:0] inject;
  logic [3:0] func_learned [3];
  logic [3:0] func [3];

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen [3] = '{0, 0, 0};

  function automatic int s_of(int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 15;
  endfunction

  function automatic int p_of(int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 4;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int S = (gi == 0) ? 1 : (gi == 1) ? 3 : 15;
    localparam int P = (gi == 0) ? 2 : (gi == 1) ? 1 : 4;
    lut_prober #(.SETTLE(S), .PASSES(P)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n[gi]),
      .start        (start[gi]),
      .probe_a      (probe_a[gi]),
      .probe_b      (probe_b[gi]),
      .dut_out      (dut_out[gi]),
      .func_learned (func_learned[gi]),
      .busy         (busy[gi]),
      .done         (done[gi]),
      .err          (err[gi])
    );
    // Unit under probe: truth table lookup, optionally corrupted.
    assign dut_out[gi] = func[gi][{probe_a[gi], probe_b[gi]}] ^ inject[gi];
  end

  // Behavioural model: phase 0 idle, 1 sweeping, 2 done; t = cycles since E0.
  int         m_ph [3];
  int         m_t [3];
  logic [3:0] m_shadow [3];
  logic [3:0] m_learned [3];
  logic       m_err [3];
  logic       m_valid [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin : model
    int   cur;
    int   n;
    logic v;
    for (int g = 0; g < 3; g++) begin
      if (!rst_n[g]) begin
        m_ph[g] = 0; m_t[g] = 0; m_shadow[g] = 4'd0;
        m_learned[g] = 4'd0; m_err[g] = 1'b0; m_valid[g] = 1'b1;
      end else if (m_valid[g]) begin
        case (m_ph[g])
          0: if (start[g]) begin
            m_ph[g] = 1; m_t[g] = 0; m_err[g] = 1'b0;
          end
          1: begin
            cur = (m_t[g] / s_of(g)) % 4;
            v = func[g][cur] ^ inject[g];
            m_t[g] = m_t[g] + 1;
            if (m_t[g] % s_of(g) == 0) begin
              n = m_t[g] / s_of(g) - 1;
              if (n < 4) m_shadow[g][cur] = v;
              else if (v != m_shadow[g][cur]) m_err[g] = 1'b1;
              if (n == 4 * p_of(g) - 1) begin
                m_ph[g] = 2;
                m_learned[g] = m_shadow[g];
              end
            end
          end
          default: m_ph[g] = 0;
        endcase
      end
    end
  end

  function automatic logic [8:0] exp_vec(int g);
    logic [1:0] pat;
    pat = (m_ph[g] == 1) ? 2'((m_t[g] / s_of(g)) % 4) : 2'd0;
    return {pat, m_ph[g] == 1, m_ph[g] == 2, m_err[g], m_learned[g]};
  endfunction

  function automatic logic [8:0] act_vec(int g);
    return {probe_a[g], probe_b[g], busy[g], done[g], err[g], func_learned[g]};
  endfunction

  // Advance n cycles, comparing every instance against the model at each negedge.
  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (m_valid[g]) begin
          n_cmp++;
          if (act_vec(g) !== exp_vec(g)) begin
            n_bad++;
            $display("FAIL cycle_check inst=%0d t=%0t dut{pa,pb,busy,done,err,fl}=%b model=%b",
                     g, $time, act_vec(g), exp_vec(g));
          end
          if (done[g] === 1'b1) done_seen[g]++;
        end
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_done(int g, int budget, output int k);
    k = 0;
    while (done[g] !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    if (done[g] !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout inst=%0d after %0d cycles", g, k);
    end
  endtask

  task automatic launch(int g);
    start[g] = 1'b1;
    step(1);
    start[g] = 1'b0;
  endtask

  initial begin
    int k;
    rst_n = 3'b000; start = 3'b000; inject = 3'b000;
    func[0] = 4'b1010; func[1] = 4'b0110; func[2] = 4'b0000;
    step(2);
    check("rst_func", func_learned[0], 4'b0000);
    check("rst_busy", busy[0], 1'b0);
    check("rst_err", err[0], 1'b0);

    // Golden 1010 with defaults; start present on first edge out of reset.
    rst_n = 3'b111;
    launch(0);
    check("e0_busy", busy[0], 1'b1);
    check("e0_probe", {probe_a[0], probe_b[0]}, 2'b00);
    wait_done(0, 50, k);
    check("lat_default", k, 8);
    check("golden_1010", func_learned[0], 4'b1010);
    check("golden_1010_err", err[0], 1'b0);

    // Start pulses mid-sweep and during DONE are ignored.
    step(1);
    done_seen[0] = 0;
    launch(0);
    step(1);
    start[0] = 1'b1; step(1); start[0] = 1'b0;
    step(6);
    check("done_at_e0p8", done[0], 1'b1);
    start[0] = 1'b1; step(1); start[0] = 1'b0;
    step(3);
    check("ignored_busy", busy[0], 1'b0);
    check("single_done", done_seen[0], 1);

    // Start held high relaunches on the first edge back in IDLE.
    start[0] = 1'b1;
    step(1);
    wait_done(0, 50, k);
    step(1);
    check("held_idle_gap", busy[0], 1'b0);
    step(1);
    check("held_relaunch", busy[0], 1'b1);
    start[0] = 1'b0;
    wait_done(0, 50, k);
    check("held_lat", k, 8);
    step(1);

    // Fault on pass-1 idx=2 with func 1111.
    func[0] = 4'b1111;
    launch(0);
    step(6);
    inject[0] = 1'b1; step(1); inject[0] = 1'b0;
    wait_done(0, 50, k);
    check("fault_func", func_learned[0], 4'b1111);
    check("fault_err", err[0], 1'b1);
    step(3);
    check("err_sticky", err[0], 1'b1);
    launch(0);
    check("err_clear", err[0], 1'b0);
    wait_done(0, 50, k);
    check("clean_err", err[0], 1'b0);
    step(1);

    // Reset at E0+5 aborts the sweep.
    func[0] = 4'b1010;
    done_seen[0] = 0;
    launch(0);
    step(4);
    rst_n[0] = 1'b0; step(1);
    check("abort_outputs", act_vec(0), 9'd0);
    rst_n[0] = 1'b1; step(3);
    check("abort_no_done", done_seen[0], 0);
    launch(0);
    wait_done(0, 50, k);
    check("after_abort_func", func_learned[0], 4'b1010);
    step(1);

    // SETTLE=3, PASSES=1, golden 0110.
    launch(1);
    wait_done(1, 100, k);
    check("lat_s3p1", k, 12);
    check("golden_0110", func_learned[1], 4'b0110);
    check("golden_0110_err", err[1], 1'b0);
    step(1);

    // All 16 codes with SETTLE=15, PASSES=4.
    for (int f = 0; f < 16; f++) begin
      func[2] = 4'(f);
      launch(2);
      wait_done(2, 400, k);
      check("lat_s15p4", k, 240);
      check("sweep_func", func_learned[2], 32'(f));
      check("sweep_err", err[2], 1'b0);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
